// File: rtl/scope_param_pkg.sv
// Shared types and helpers for the scope_param_bank family.
// Holds the restore FSM state enum, the MODE encodings and the
// per-channel initial value calculation used by the bank and its channels.
package scope_param_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_e;

  localparam int unsigned MODE_HOLD   = 0;
  localparam int unsigned MODE_COUNT  = 1;

  // Wide enough that INIT + ch*STRIDE never overflows before the caller truncates to WIDTH.
  localparam int unsigned INIT_CALC_W = 64;

  // Initial value of channel ch; the caller truncates the result to its WIDTH.
  function automatic logic [INIT_CALC_W-1:0] init_val(input int unsigned ch,
                                                      input int unsigned init,
                                                      input int unsigned stride);
    return INIT_CALC_W'(init) + INIT_CALC_W'(ch) * INIT_CALC_W'(stride);
  endfunction

endpackage

// File: rtl/scope_param_chan.sv
// One channel of the parameter bank: a WIDTH-bit register with reload,
// load and count controls, plus a registered wrap pulse.
// Ports:
//   clk, rst_n   clock, async active-low reset (value -> INIT_VAL)
//   reload       load INIT_VAL (highest priority)
//   load         load load_data
//   load_data    write value
//   count        increment by one (lowest priority)
//   value        current channel value
//   wrap         one-cycle pulse when a count takes value from all-ones to zero
module scope_param_chan #(
  parameter int unsigned        WIDTH    = 32,
  parameter logic [WIDTH-1:0]   INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             count,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  // Value register: reload > load > count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT_VAL;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (reload) begin
        value <= INIT_VAL;
      end else if (load) begin
        value <= load_data;
      end else if (count) begin
        value <= value + WIDTH'(1);
        wrap  <= (value == '1);
      end
    end
  end

endmodule

// File: rtl/scope_param_bank.sv
// Bank of CHANNELS runtime-writable, parameter-initialised values.
// Each channel resets to (INIT + ch*STRIDE) mod 2^WIDTH, can be overwritten
// through a valid/ready port, optionally free-runs as a counter (MODE=1),
// and is restored to its initial value by a one-channel-per-cycle walk.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_valid/wr_ready   write handshake; wr_ready is combinational (low on restore)
//   wr_ch, wr_data      write target channel and value
//   restore             request to reload all channels
//   en                  count enable (MODE=1 only)
//   o                   channel values, channel ch at [ch*WIDTH +: WIDTH]
//   wrap                per-channel counter wrap pulse
//   err                 pulse on an accepted write to a non-existent channel
//   busy                high while the restore walk runs
module scope_param_bank
  import scope_param_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned INIT     = 32'd11,
  parameter int unsigned STRIDE   = 0,
  parameter int unsigned MODE     = 0,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [CW-1:0]             wr_ch,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      restore,
  input  logic                      en,
  output logic [CHANNELS*WIDTH-1:0] o,
  output logic [CHANNELS-1:0]       wrap,
  output logic                      err,
  output logic                      busy
);

  state_e        state_q, state_d;
  logic [CW-1:0] ridx_q, ridx_d;
  logic          wr_acc_c;
  logic          wr_hit_c;
  logic          count_c;

  // State and restore index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      ridx_q  <= ridx_d;
    end
  end

  // Next state, restore walk and write handshake.
  always_comb begin
    state_d  = state_q;
    ridx_d   = ridx_q;
    wr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // A restore request blocks a same-cycle write so the walk starts from clean values.
        wr_ready = !restore;
        if (restore) begin
          state_d = RESTORE;
          ridx_d  = '0;
        end
      end
      RESTORE: begin
        if (ridx_q == CW'(CHANNELS - 1)) begin
          state_d = IDLE;
          ridx_d  = '0;
        end else begin
          ridx_d = ridx_q + CW'(1);
        end
      end
    endcase
  end

  assign busy     = (state_q == RESTORE);
  assign wr_acc_c = wr_valid && wr_ready;
  assign wr_hit_c = 32'(wr_ch) < CHANNELS;
  assign count_c  = (MODE == MODE_COUNT) && en && (state_q == IDLE);

  // Out-of-range write flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= wr_acc_c && !wr_hit_c;
    end
  end

  // One channel register per slot, each with its own parameter-derived reset value.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    localparam logic [WIDTH-1:0] CH_INIT = WIDTH'(init_val(ch, INIT, STRIDE));

    scope_param_chan #(
      .WIDTH    (WIDTH),
      .INIT_VAL (CH_INIT)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .reload    (busy && (ridx_q == CW'(ch))),
      .load      (wr_acc_c && (wr_ch == CW'(ch))),
      .load_data (wr_data),
      .count     (count_c),
      .value     (o[ch*WIDTH +: WIDTH]),
      .wrap      (wrap[ch])
    );
  end

endmodule

// File: tb/tb_scope_param_bank.sv
// Self-checking bench for scope_param_bank.
// dut   : WIDTH=32, CHANNELS=4, INIT=11, STRIDE=5, MODE=0 (table-driven writes/restore)
// dut_b : WIDTH=4,  CHANNELS=6, INIT=14, STRIDE=3, MODE=1 (counting, err, random vs model)
// dut_c : CHANNELS=1 (single-cycle restore, err on wr_ch=1)
// dut_d : all defaults (reset values only)
module tb_scope_param_bank;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut signals
  logic         a_wv = 1'b0, a_rdy, a_rs = 1'b0, a_en = 1'b0, a_err, a_busy;
  logic [1:0]   a_ch = '0;
  logic [31:0]  a_wd = '0;
  logic [127:0] a_o;
  logic [3:0]   a_wrap;

  // dut_b signals
  logic         b_wv = 1'b0, b_rdy, b_rs = 1'b0, b_en = 1'b0, b_err, b_busy;
  logic [2:0]   b_ch = '0;
  logic [3:0]   b_wd = '0;
  logic [23:0]  b_o;
  logic [5:0]   b_wrap;

  // dut_c signals
  logic         c_wv = 1'b0, c_rdy, c_rs = 1'b0, c_en = 1'b0, c_err, c_busy;
  logic [0:0]   c_ch = '0;
  logic [31:0]  c_wd = '0;
  logic [31:0]  c_o;
  logic [0:0]   c_wrap;

  // dut_d signals
  logic         d_wv = 1'b0, d_rdy, d_rs = 1'b0, d_en = 1'b0, d_err, d_busy;
  logic [1:0]   d_ch = '0;
  logic [31:0]  d_wd = '0;
  logic [127:0] d_o;
  logic [3:0]   d_wrap;

  scope_param_bank #(.WIDTH(32), .CHANNELS(4), .INIT(11), .STRIDE(5), .MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(a_wv), .wr_ready(a_rdy), .wr_ch(a_ch),
    .wr_data(a_wd), .restore(a_rs), .en(a_en), .o(a_o), .wrap(a_wrap),
    .err(a_err), .busy(a_busy));

  scope_param_bank #(.WIDTH(4), .CHANNELS(6), .INIT(14), .STRIDE(3), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wv), .wr_ready(b_rdy), .wr_ch(b_ch),
    .wr_data(b_wd), .restore(b_rs), .en(b_en), .o(b_o), .wrap(b_wrap),
    .err(b_err), .busy(b_busy));

  scope_param_bank #(.CHANNELS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_valid(c_wv), .wr_ready(c_rdy), .wr_ch(c_ch),
    .wr_data(c_wd), .restore(c_rs), .en(c_en), .o(c_o), .wrap(c_wrap),
    .err(c_err), .busy(c_busy));

  scope_param_bank dut_d (
    .clk(clk), .rst_n(rst_n), .wr_valid(d_wv), .wr_ready(d_rdy), .wr_ch(d_ch),
    .wr_data(d_wd), .restore(d_rs), .en(d_en), .o(d_o), .wrap(d_wrap),
    .err(d_err), .busy(d_busy));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- table for dut (STRIDE=5, hold mode) ----------------
  typedef struct packed {
    logic             wv;
    logic [1:0]       ch;
    logic [31:0]      wd;
    logic             rs;
    logic             rdy;   // wr_ready with these inputs applied, before the edge
    logic [3:0][31:0] o;     // channel values after the edge
    logic             busy;  // busy after the edge
  } a_vec_t;

  function automatic a_vec_t av(input logic wv, input logic [1:0] ch, input logic [31:0] wd,
                                input logic rs, input logic rdy,
                                input logic [31:0] o3, input logic [31:0] o2,
                                input logic [31:0] o1, input logic [31:0] o0,
                                input logic busy);
    a_vec_t v;
    v.wv = wv; v.ch = ch; v.wd = wd; v.rs = rs; v.rdy = rdy;
    v.o[3] = o3; v.o[2] = o2; v.o[1] = o1; v.o[0] = o0;
    v.busy = busy;
    return v;
  endfunction

  // ---------------- reference model for dut_b ----------------
  localparam int BCH = 6;
  int bv [BCH];
  int brem;   // channels still to be reloaded by the current restore

  function automatic int bini(input int ch);
    return (14 + 3 * ch) % 16;
  endfunction

  task automatic b_model_reset();
    for (int c = 0; c < BCH; c++) bv[c] = bini(c);
    brem = 0;
  endtask

  task automatic b_cycle(input logic wv, input logic [2:0] wch, input logic [3:0] wd,
                         input logic rs, input logic en);
    logic [23:0] eo;
    logic [5:0]  ew;
    logic        ee, erdy, acc;
    b_wv = wv; b_ch = wch; b_wd = wd; b_rs = rs; b_en = en;
    #1;
    erdy = (brem == 0) && !rs;
    chk("b_ready", 128'(b_rdy), 128'(erdy));
    acc = wv && erdy;
    ew  = '0;
    ee  = 1'b0;
    if (brem > 0) begin
      bv[BCH - brem] = bini(BCH - brem);
      brem--;
    end else begin
      for (int c = 0; c < BCH; c++) begin
        if (acc && int'(wch) == c) begin
          bv[c] = int'(wd);
        end else if (en) begin
          bv[c] = (bv[c] + 1) % 16;
          ew[c] = (bv[c] == 0);
        end
      end
      ee = acc && (int'(wch) >= BCH);
      if (rs) brem = BCH;
    end
    for (int c = 0; c < BCH; c++) eo[c*4 +: 4] = 4'(bv[c]);
    @(posedge clk);
    #1;
    chk("b_o", 128'(b_o), 128'(eo));
    chk("b_wrap", 128'(b_wrap), 128'(ew));
    chk("b_err", 128'(b_err), 128'(ee));
    chk("b_busy", 128'(b_busy), 128'(brem > 0));
  endtask

  localparam logic [127:0] A_INIT = {32'd26, 32'd21, 32'd16, 32'd11};

  initial begin
    a_vec_t tbl [10];

    tbl[0] = av(1'b1, 2'd2, 32'hDEAD, 1'b0, 1'b1, 32'd26, 32'hDEAD, 32'd16, 32'd11, 1'b0);
    tbl[1] = av(1'b1, 2'd0, 32'd1,    1'b0, 1'b1, 32'd26, 32'hDEAD, 32'd16, 32'd1,  1'b0);
    tbl[2] = av(1'b1, 2'd1, 32'd3,    1'b0, 1'b1, 32'd26, 32'hDEAD, 32'd3,  32'd1,  1'b0);
    tbl[3] = av(1'b1, 2'd3, 32'd2,    1'b0, 1'b1, 32'd2,  32'hDEAD, 32'd3,  32'd1,  1'b0);
    tbl[4] = av(1'b1, 2'd1, 32'd5,    1'b1, 1'b0, 32'd2,  32'hDEAD, 32'd3,  32'd1,  1'b1);
    tbl[5] = av(1'b1, 2'd1, 32'd5,    1'b1, 1'b0, 32'd2,  32'hDEAD, 32'd3,  32'd11, 1'b1);
    tbl[6] = av(1'b0, 2'd0, 32'd0,    1'b0, 1'b0, 32'd2,  32'hDEAD, 32'd16, 32'd11, 1'b1);
    tbl[7] = av(1'b0, 2'd0, 32'd0,    1'b0, 1'b0, 32'd2,  32'd21,   32'd16, 32'd11, 1'b1);
    tbl[8] = av(1'b0, 2'd0, 32'd0,    1'b0, 1'b0, 32'd26, 32'd21,   32'd16, 32'd11, 1'b0);
    tbl[9] = av(1'b1, 2'd0, 32'd7,    1'b0, 1'b1, 32'd26, 32'd21,   32'd16, 32'd7,  1'b0);

    b_model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset values
    chk("d_o_reset", d_o, {4{32'd11}});
    chk("d_ready_reset", 128'(d_rdy), 128'(1'b1));
    chk("d_busy_reset", 128'(d_busy), 128'(1'b0));
    chk("d_wrap_err_reset", 128'({d_wrap, d_err}), 128'(0));
    chk("a_o_reset", a_o, A_INIT);
    chk("a_ready_reset", 128'(a_rdy), 128'(1'b1));
    chk("c_o_reset", 128'(c_o), 128'(32'd11));

    // Table-driven writes, restore with blocked write, ignored second restore
    for (int i = 0; i < 10; i++) begin
      a_wv = tbl[i].wv; a_ch = tbl[i].ch; a_wd = tbl[i].wd; a_rs = tbl[i].rs;
      #1;
      chk($sformatf("a_ready[%0d]", i), 128'(a_rdy), 128'(tbl[i].rdy));
      step();
      chk($sformatf("a_o[%0d]", i), a_o, 128'(tbl[i].o));
      chk($sformatf("a_busy[%0d]", i), 128'(a_busy), 128'(tbl[i].busy));
      chk($sformatf("a_wrap_err[%0d]", i), 128'({a_wrap, a_err}), 128'(0));
    end
    a_wv = 1'b0; a_rs = 1'b0;

    // Single-channel instance: err on wr_ch=1, one busy cycle restore
    c_wv = 1'b1; c_ch = 1'b0; c_wd = 32'd99;
    step();
    chk("c_write", 128'(c_o), 128'(32'd99));
    chk("c_err_ok", 128'(c_err), 128'(1'b0));
    c_ch = 1'b1; c_wd = 32'd5;
    step();
    chk("c_err_pulse", 128'(c_err), 128'(1'b1));
    chk("c_err_nochange", 128'(c_o), 128'(32'd99));
    c_wv = 1'b0;
    step();
    chk("c_err_clear", 128'(c_err), 128'(1'b0));
    c_rs = 1'b1;
    #1;
    chk("c_ready_restore", 128'(c_rdy), 128'(1'b0));
    step();
    c_rs = 1'b0;
    chk("c_busy1", 128'(c_busy), 128'(1'b1));
    chk("c_o_before_reload", 128'(c_o), 128'(32'd99));
    #1;
    chk("c_ready_busy", 128'(c_rdy), 128'(1'b0));
    step();
    chk("c_busy_done", 128'(c_busy), 128'(1'b0));
    chk("c_o_restored", 128'(c_o), 128'(32'd11));
    chk("c_ready_back", 128'(c_rdy), 128'(1'b1));
    chk("c_wrap", 128'(c_wrap), 128'(0));

    // Reset in the middle of a restore walk
    a_wv = 1'b1;
    a_ch = 2'd1; a_wd = 32'd1; step();
    a_ch = 2'd2; a_wd = 32'd2; step();
    a_ch = 2'd3; a_wd = 32'd3; step();
    a_wv = 1'b0; a_rs = 1'b1;
    step();
    a_rs = 1'b0;
    step();
    step();
    chk("a_partial_restore", a_o, {32'd3, 32'd2, 32'd16, 32'd11});
    chk("a_partial_busy", 128'(a_busy), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_async_reset_o", a_o, A_INIT);
    chk("a_async_reset_busy", 128'(a_busy), 128'(1'b0));
    chk("a_async_reset_ready", 128'(a_rdy), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    b_model_reset();
    step();
    chk("a_idle_after_reset", 128'(a_busy), 128'(1'b0));
    chk("a_o_after_reset", a_o, A_INIT);
    a_wv = 1'b1; a_ch = 2'd2; a_wd = 32'd9;
    step();
    a_wv = 1'b0;
    chk("a_write_after_reset", a_o, {32'd26, 32'd9, 32'd16, 32'd11});

    // Counting bank: ch0 14 -> 15, 0 (wrap), 1
    b_cycle(1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
    chk("b_ch0_15", 128'(b_o[3:0]), 128'(4'd15));
    chk("b_wrap0_lo", 128'(b_wrap[0]), 128'(1'b0));
    b_cycle(1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
    chk("b_ch0_0", 128'(b_o[3:0]), 128'(4'd0));
    chk("b_wrap0_hi", 128'(b_wrap[0]), 128'(1'b1));
    b_cycle(1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
    chk("b_ch0_1", 128'(b_o[3:0]), 128'(4'd1));
    chk("b_wrap0_done", 128'(b_wrap[0]), 128'(1'b0));
    // Write beats count
    b_cycle(1'b1, 3'd0, 4'd7, 1'b0, 1'b1);
    chk("b_write_beats_count", 128'(b_o[3:0]), 128'(4'd7));
    // Out-of-range channel
    b_cycle(1'b1, 3'd7, 4'hA, 1'b0, 1'b0);
    chk("b_err_ch7", 128'(b_err), 128'(1'b1));
    b_cycle(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
    chk("b_err_once", 128'(b_err), 128'(1'b0));
    // Restore with same-cycle write, then a restore while busy
    b_cycle(1'b1, 3'd2, 4'd5, 1'b1, 1'b1);
    b_cycle(1'b1, 3'd3, 4'd6, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) b_cycle(1'b0, 3'd0, 4'd0, 1'b0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      b_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
